param_sequencer: RTL
====================

// Module: param_sequencer
//
// PURPOSE
//   Parametrised next-generation CPU control sequencer. Walks each instruction line
//   through READ -> LOAD (NLOAD cycles) -> CALC (multicycle) -> WRITE -> NXT.
//   Adds the following over the fixed sequencer:
//   - pipeline stall
//   - single-step mode
//   - CALC watchdog timeout
//   - instruction-count limit
//   - coded error reporting
//   - clear-to-restart from FINISH/ERR
//   Drives datapath/decoder enables in the CPU top level.
//
// PARAMETERS
//   NLOAD        3    LOAD-phase cycles per line (>=1)
//   CALC_TIMEOUT 255  max cycles in SCALC before watchdog error; 0 = watchdog disabled
//   MAX_INSTR    0    lines allowed before limit error; 0 = unlimited
//   CW           8    width of calc_cnt
//   ICW          16   width of instr_cnt
//
// PORTS
//   clk        in   1              system clock, rising edge
//   rst        in   1              asynchronous reset, active-high
//   start      in   1              leave SRST toward SREAD
//   nxt_line   in   1              CALC complete, go to SWRITE
//   finish     in   1              program end, go to SFINISH (from SCALC)
//   err        in   1              external fault, go to SERR from any state
//   stall      in   1              freeze state and counters this cycle
//   step_mode  in   1              1 = pause in SHOLD after every SNXT
//   step       in   1              release SHOLD
//   clear      in   1              SFINISH/SERR -> SRST; ignored elsewhere
//   state      out  4              current state encoding
//   load_idx   out  $clog2(NLOAD)  LOAD sub-cycle index, 0..NLOAD-1 (width 1 if NLOAD==1)
//   calc_cnt   out  CW             cycles spent in current SCALC
//   instr_cnt  out  ICW            completed lines (incremented on SNXT)
//   err_code   out  2              0 none, 1 external, 2 watchdog, 3 instr limit
//   busy       out  1              state not in {SRST, SFINISH, SERR, SHOLD}
//   done       out  1              state == SFINISH
//
// BEHAVIOUR
//   - State encodings (state port): SRST=0, SREAD=1, SLOAD=2, SCALC=3, SWRITE=4,
//     SNXT=5, SFINISH=6, SERR=7, SHOLD=8.
//   - Reset: rst=1 asynchronously forces state=SRST and clears load_idx, calc_cnt,
//     instr_cnt and err_code to 0, so busy=0 and done=0. This holds mid-operation and
//     overrides every other input.
//   - All outputs are registered or decoded purely from state; no combinational path
//     from inputs to outputs.
//   - Input priority per cycle, after rst: err > clear > stall > normal transition.
//   - err=1 (any state, including SERR): next state SERR.
//     - err_code is set to 1 only if err_code was 0; the first error code is sticky.
//   - clear=1 in SFINISH/SERR: next state SRST, err_code := 0, instr_cnt := 0.
//     clear has no effect in any other state.
//   - stall=1 in SREAD/SLOAD/SCALC/SWRITE/SNXT: state, load_idx, calc_cnt and
//     instr_cnt hold; the watchdog does not advance. stall is ignored in the other states.
//   - Transitions:
//     - SRST -> SREAD when start==1, else stay.
//     - SREAD -> SLOAD with load_idx := 0.
//     - SLOAD: load_idx increments each cycle; when load_idx==NLOAD-1, go SCALC with
//       calc_cnt := 0. SLOAD therefore lasts exactly NLOAD cycles.
//     - SCALC, first match wins:
//       1. finish==1 -> SFINISH
//       2. nxt_line==1 -> SWRITE
//       3. CALC_TIMEOUT!=0 && calc_cnt==CALC_TIMEOUT-1 -> SERR, err_code := 2
//       4. otherwise stay, calc_cnt += 1, saturating at all-ones.
//     - SWRITE -> SNXT.
//     - SNXT: instr_cnt += 1 (wraps at 2^ICW), then:
//       1. MAX_INSTR!=0 && new instr_cnt==MAX_INSTR -> SERR, err_code := 3
//       2. else step_mode==1 -> SHOLD
//       3. else SREAD.
//     - SHOLD -> SREAD when step==1. The step pulse must be sampled in SHOLD;
//       earlier pulses are not remembered.
//     - SFINISH, SERR: stay until clear or rst.
//   - Latency:
//     - minimum line, no stalls: 1 (READ) + NLOAD + 1 (CALC) + 1 (WRITE) + 1 (NXT)
//       = NLOAD+4 cycles;
//     - start sampled high -> state==SREAD on the next edge.
//   - Simultaneous finish and nxt_line in SCALC: finish wins.
//   - Simultaneous finish and watchdog expiry: finish wins.
//   - Simultaneous err and clear in SERR: stays SERR, err_code unchanged.
//
// TESTING
//   1. Reset, start=1 one cycle, NLOAD=3, nxt_line high on 2nd SCALC cycle
//      -> state sequence 1,2,2,2,3,3,4,5,1; instr_cnt=1; load_idx reads 0,1,2.
//   2. CALC_TIMEOUT=4, no nxt_line/finish -> SERR after 4 SCALC cycles,
//      err_code=2, busy=0; then clear=1 -> SRST, err_code=0.
//   3. stall=1 for 3 cycles in SLOAD at load_idx=1
//      -> state and load_idx frozen; line completes 3 cycles later than unstalled.
//   4. step_mode=1 -> after SNXT, state=8 and holds 10 cycles;
//      step=1 -> SREAD next cycle.
//   5. MAX_INSTR=2 -> second SNXT goes to SERR with err_code=3, instr_cnt=2.
//      A later err=1 keeps err_code=3.
//   6. rst asserted mid-SCALC with calc_cnt=5 -> immediately state=0, all counters 0;
//      finish and nxt_line together in SCALC -> SFINISH, done=1.

Source files
------------

// File: rtl/param_sequencer.sv
// Parametrised CPU control sequencer: READ -> LOAD -> CALC -> WRITE -> NXT,
// with stall, single-step hold, CALC watchdog, line limit and sticky error codes.
module param_sequencer #(
    parameter int NLOAD        = 3,
    parameter int CALC_TIMEOUT = 255,
    parameter int MAX_INSTR    = 0,
    parameter int CW           = 8,
    parameter int ICW          = 16,
    localparam int LW          = (NLOAD > 1) ? $clog2(NLOAD) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           nxt_line,
    input  logic           finish,
    input  logic           err,
    input  logic           stall,
    input  logic           step_mode,
    input  logic           step,
    input  logic           clear,
    output logic [3:0]     state,
    output logic [LW-1:0]  load_idx,
    output logic [CW-1:0]  calc_cnt,
    output logic [ICW-1:0] instr_cnt,
    output logic [1:0]     err_code,
    output logic           busy,
    output logic           done
);

    localparam logic [3:0] SRST    = 4'd0;
    localparam logic [3:0] SREAD   = 4'd1;
    localparam logic [3:0] SLOAD   = 4'd2;
    localparam logic [3:0] SCALC   = 4'd3;
    localparam logic [3:0] SWRITE  = 4'd4;
    localparam logic [3:0] SNXT    = 4'd5;
    localparam logic [3:0] SFINISH = 4'd6;
    localparam logic [3:0] SERR    = 4'd7;
    localparam logic [3:0] SHOLD   = 4'd8;

    localparam logic [LW-1:0]  LOAD_LAST = LW'(NLOAD - 1);
    localparam logic [CW-1:0]  WD_LAST   = CW'(CALC_TIMEOUT - 1);
    localparam logic [ICW-1:0] LIMIT     = ICW'(MAX_INSTR);
    localparam bit             WD_ON     = (CALC_TIMEOUT != 0);
    localparam bit             LIM_ON    = (MAX_INSTR != 0);

    logic           active;
    logic           parked;
    logic [ICW-1:0] instr_inc;

    // Only the line-walking states advance, and only they honour stall.
    assign active    = (state == SREAD) || (state == SLOAD) ||
                       (state == SCALC) || (state == SWRITE) ||
                       (state == SNXT);
    assign parked    = (state == SFINISH) || (state == SERR);
    assign instr_inc = instr_cnt + ICW'(1);
    assign busy      = active;
    assign done      = (state == SFINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SRST;
            load_idx  <= '0;
            calc_cnt  <= '0;
            instr_cnt <= '0;
            err_code  <= 2'd0;
        end else if (err) begin
            state <= SERR;
            if (err_code == 2'd0)
                err_code <= 2'd1;
        end else if (clear && parked) begin
            state     <= SRST;
            err_code  <= 2'd0;
            instr_cnt <= '0;
        end else if (!(stall && active)) begin
            case (state)
                SRST:
                    if (start)
                        state <= SREAD;
                SREAD: begin
                    state    <= SLOAD;
                    load_idx <= '0;
                end
                SLOAD:
                    if (load_idx == LOAD_LAST) begin
                        state    <= SCALC;
                        calc_cnt <= '0;
                    end else begin
                        load_idx <= load_idx + LW'(1);
                    end
                SCALC:
                    if (finish)
                        state <= SFINISH;
                    else if (nxt_line)
                        state <= SWRITE;
                    else if (WD_ON && calc_cnt == WD_LAST) begin
                        state    <= SERR;
                        err_code <= 2'd2;
                    end else if (calc_cnt != '1)
                        calc_cnt <= calc_cnt + CW'(1);
                SWRITE:
                    state <= SNXT;
                SNXT: begin
                    instr_cnt <= instr_inc;
                    if (LIM_ON && instr_inc == LIMIT) begin
                        state    <= SERR;
                        err_code <= 2'd3;
                    end else if (step_mode)
                        state <= SHOLD;
                    else
                        state <= SREAD;
                end
                SHOLD:
                    if (step)
                        state <= SREAD;
                SFINISH, SERR: ;
                default:
                    state <= SRST;
            endcase
        end
    end

endmodule
